// File: rtl/mlp_argmax_scanner_pkg.sv
// Shared MLP output-stage definitions: scan state encoding, default layer
// dimensions and an elaboration-time log2 helper.
package mlp_argmax_scanner_pkg;

  localparam int DEF_CLASS_NB    = 10;
  localparam int DEF_SCORE_WIDTH = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mlp_argmax_scanner_if.sv
// Start/done handshake, score vector and result bundle of the arg-max stage.
interface mlp_argmax_scanner_if
  import mlp_argmax_scanner_pkg::*;
#(
  parameter int CLASS_NB     = DEF_CLASS_NB,
  parameter int SCORE_WIDTH  = DEF_SCORE_WIDTH,
  parameter int IDX_WIDTH    = 4,
  parameter int MARGIN_WIDTH = 16
);

  logic                            start;
  logic [CLASS_NB*SCORE_WIDTH-1:0] scores_in;
  logic [MARGIN_WIDTH-1:0]         threshold;
  logic [IDX_WIDTH-1:0]            predict_digit;
  logic [IDX_WIDTH-1:0]            second_digit;
  logic [MARGIN_WIDTH-1:0]         margin;
  logic                            ambiguous;
  logic                            busy;
  logic                            done;

  modport master (
    output start, scores_in, threshold,
    input  predict_digit, second_digit, margin, ambiguous, busy, done
  );

  modport slave (
    input  start, scores_in, threshold,
    output predict_digit, second_digit, margin, ambiguous, busy, done
  );

endinterface

// File: rtl/mlp_score_compare.sv
// Combinational "challenger beats incumbent" test; TIE_HIGH lets equal scores win.
module mlp_score_compare #(
  parameter int SCORE_WIDTH   = 40,
  parameter int SIGNED_SCORES = 1,
  parameter int TIE_HIGH      = 0
) (
  input  logic [SCORE_WIDTH-1:0] cand_i,
  input  logic [SCORE_WIDTH-1:0] ref_i,
  output logic                   beats_o
);

  logic greater;
  logic equal;

  if (SIGNED_SCORES != 0) begin : g_signed
    assign greater = $signed(cand_i) > $signed(ref_i);
  end else begin : g_unsigned
    assign greater = cand_i > ref_i;
  end

  assign equal   = (cand_i == ref_i);
  assign beats_o = greater | ((TIE_HIGH != 0) && equal);

endmodule

// File: rtl/mlp_argmax_scanner.sv
// Sequential arg-max / top-2 scanner: one class per enabled cycle, then a
// registered result with a one-cycle done pulse.
//   state | meaning
//   IDLE  | waiting for start; results hold
//   SCAN  | comparing class idx against best and second
//   DONE  | latch results, pulse done, back to IDLE
module mlp_argmax_scanner
  import mlp_argmax_scanner_pkg::*;
#(
  parameter int CLASS_NB      = DEF_CLASS_NB,
  parameter int SCORE_WIDTH   = DEF_SCORE_WIDTH,
  parameter int IDX_WIDTH     = 4,
  parameter int SIGNED_SCORES = 1,
  parameter int TIE_HIGH      = 0,
  parameter int MARGIN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  mlp_argmax_scanner_if.slave  bus
);

  if (CLASS_NB < 2) begin : g_err_class_nb
    $error("mlp_argmax_scanner: CLASS_NB must be at least 2");
  end
  if (clog2(CLASS_NB) > IDX_WIDTH) begin : g_err_idx_width
    $error("mlp_argmax_scanner: IDX_WIDTH too small for CLASS_NB");
  end

  localparam int DIFF_W = SCORE_WIDTH + 1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_MIN =
    (SIGNED_SCORES != 0) ? {1'b1, {(SCORE_WIDTH-1){1'b0}}} : '0;

  scan_state_e              state_q, state_d;
  logic [IDX_WIDTH-1:0]     idx_q, idx_d;
  logic [SCORE_WIDTH-1:0]   score_mem_q [CLASS_NB];
  logic [SCORE_WIDTH-1:0]   best_q, best_d;
  logic [SCORE_WIDTH-1:0]   second_q, second_d;
  logic [IDX_WIDTH-1:0]     best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0]     second_idx_q, second_idx_d;
  logic [IDX_WIDTH-1:0]     predict_q, predict_d;
  logic [IDX_WIDTH-1:0]     runner_q, runner_d;
  logic [MARGIN_WIDTH-1:0]  margin_q, margin_d;
  logic                     ambiguous_q, ambiguous_d;
  logic                     done_q, done_d;
  logic                     capture;

  logic [SCORE_WIDTH-1:0]   score_cur;
  logic                     beats_best;
  logic                     beats_second;
  logic [DIFF_W-1:0]        best_ext, second_ext, diff;
  logic [MARGIN_WIDTH-1:0]  margin_sat;

  assign score_cur = score_mem_q[idx_q];

  mlp_score_compare #(
    .SCORE_WIDTH   (SCORE_WIDTH),
    .SIGNED_SCORES (SIGNED_SCORES),
    .TIE_HIGH      (TIE_HIGH)
  ) u_cmp_best (
    .cand_i  (score_cur),
    .ref_i   (best_q),
    .beats_o (beats_best)
  );

  mlp_score_compare #(
    .SCORE_WIDTH   (SCORE_WIDTH),
    .SIGNED_SCORES (SIGNED_SCORES),
    .TIE_HIGH      (TIE_HIGH)
  ) u_cmp_second (
    .cand_i  (score_cur),
    .ref_i   (second_q),
    .beats_o (beats_second)
  );

  // One extra bit keeps best - second exact; second never exceeds best.
  if (SIGNED_SCORES != 0) begin : g_sext
    assign best_ext   = {best_q[SCORE_WIDTH-1], best_q};
    assign second_ext = {second_q[SCORE_WIDTH-1], second_q};
  end else begin : g_zext
    assign best_ext   = {1'b0, best_q};
    assign second_ext = {1'b0, second_q};
  end

  assign diff = best_ext - second_ext;

  if (DIFF_W > MARGIN_WIDTH) begin : g_sat
    assign margin_sat = (|diff[DIFF_W-1:MARGIN_WIDTH]) ? '1 : diff[MARGIN_WIDTH-1:0];
  end else begin : g_nosat
    assign margin_sat = MARGIN_WIDTH'(diff);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_d       = best_q;
    second_d     = second_q;
    best_idx_d   = best_idx_q;
    second_idx_d = second_idx_q;
    predict_d    = predict_q;
    runner_d     = runner_q;
    margin_d     = margin_q;
    ambiguous_d  = ambiguous_q;
    done_d       = 1'b0;
    capture      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx_q == '0) begin
          best_d       = score_cur;
          best_idx_d   = '0;
          second_d     = SCORE_MIN;
          second_idx_d = '0;
        end else if (beats_best) begin
          second_d     = best_q;
          second_idx_d = best_idx_q;
          best_d       = score_cur;
          best_idx_d   = idx_q;
        end else if (beats_second) begin
          second_d     = score_cur;
          second_idx_d = idx_q;
        end
        if (idx_q == IDX_WIDTH'(CLASS_NB - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        predict_d   = best_idx_q;
        runner_d    = second_idx_q;
        margin_d    = margin_sat;
        ambiguous_d = (margin_sat < bus.threshold);
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      best_q       <= '0;
      second_q     <= '0;
      best_idx_q   <= '0;
      second_idx_q <= '0;
      predict_q    <= '0;
      runner_q     <= '0;
      margin_q     <= '0;
      ambiguous_q  <= 1'b0;
      done_q       <= 1'b0;
    end else if (en_i) begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      second_q     <= second_d;
      best_idx_q   <= best_idx_d;
      second_idx_q <= second_idx_d;
      predict_q    <= predict_d;
      runner_q     <= runner_d;
      margin_q     <= margin_d;
      ambiguous_q  <= ambiguous_d;
      done_q       <= done_d;
    end
  end

  // Private copy so upstream may change scores_in while the scan runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CLASS_NB; i++) score_mem_q[i] <= '0;
    end else if (en_i && capture) begin
      for (int i = 0; i < CLASS_NB; i++) begin
        score_mem_q[i] <= bus.scores_in[i*SCORE_WIDTH +: SCORE_WIDTH];
      end
    end
  end

  assign bus.predict_digit = predict_q;
  assign bus.second_digit  = runner_q;
  assign bus.margin        = margin_q;
  assign bus.ambiguous     = ambiguous_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mlp_argmax_scanner.sv
// Scoreboard bench: three scanner variants (default, TIE_HIGH=1, unsigned)
// share one stimulus stream; a monitor checks every done against the queue.
module tb_mlp_argmax_scanner;

  localparam int NC = 10;
  localparam int SW = 40;
  localparam int IW = 4;
  localparam int MW = 16;

  typedef struct packed {
    logic [IW-1:0] pd;
    logic [IW-1:0] sd;
    logic [MW-1:0] mg;
    logic          amb;
  } res_t;

  typedef struct packed {
    res_t [2:0]  r;
    logic [31:0] cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic            start;
  logic [NC*SW-1:0] scores;
  logic [MW-1:0]   thr;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [IW-1:0] pd [3];
  logic [IW-1:0] sd [3];
  logic [MW-1:0] mg [3];
  logic          amb [3];
  logic          by [3];
  logic          dn [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mlp_argmax_scanner_if #(.CLASS_NB(NC), .SCORE_WIDTH(SW), .IDX_WIDTH(IW), .MARGIN_WIDTH(MW)) b0 ();
  mlp_argmax_scanner_if #(.CLASS_NB(NC), .SCORE_WIDTH(SW), .IDX_WIDTH(IW), .MARGIN_WIDTH(MW)) b1 ();
  mlp_argmax_scanner_if #(.CLASS_NB(NC), .SCORE_WIDTH(SW), .IDX_WIDTH(IW), .MARGIN_WIDTH(MW)) b2 ();

  assign b0.start = start;  assign b0.scores_in = scores;  assign b0.threshold = thr;
  assign b1.start = start;  assign b1.scores_in = scores;  assign b1.threshold = thr;
  assign b2.start = start;  assign b2.scores_in = scores;  assign b2.threshold = thr;

  mlp_argmax_scanner #(.CLASS_NB(NC), .SCORE_WIDTH(SW), .IDX_WIDTH(IW),
    .SIGNED_SCORES(1), .TIE_HIGH(0), .MARGIN_WIDTH(MW))
    u_dut0 (.clk(clk), .reset(reset), .en_i(en), .bus(b0));
  mlp_argmax_scanner #(.CLASS_NB(NC), .SCORE_WIDTH(SW), .IDX_WIDTH(IW),
    .SIGNED_SCORES(1), .TIE_HIGH(1), .MARGIN_WIDTH(MW))
    u_dut1 (.clk(clk), .reset(reset), .en_i(en), .bus(b1));
  mlp_argmax_scanner #(.CLASS_NB(NC), .SCORE_WIDTH(SW), .IDX_WIDTH(IW),
    .SIGNED_SCORES(0), .TIE_HIGH(0), .MARGIN_WIDTH(MW))
    u_dut2 (.clk(clk), .reset(reset), .en_i(en), .bus(b2));

  assign pd[0] = b0.predict_digit; assign sd[0] = b0.second_digit; assign mg[0] = b0.margin;
  assign amb[0] = b0.ambiguous;    assign by[0] = b0.busy;          assign dn[0] = b0.done;
  assign pd[1] = b1.predict_digit; assign sd[1] = b1.second_digit; assign mg[1] = b1.margin;
  assign amb[1] = b1.ambiguous;    assign by[1] = b1.busy;          assign dn[1] = b1.done;
  assign pd[2] = b2.predict_digit; assign sd[2] = b2.second_digit; assign mg[2] = b2.margin;
  assign amb[2] = b2.ambiguous;    assign by[2] = b2.busy;          assign dn[2] = b2.done;

  function automatic res_t mk(input int p, input int s, input int m, input int a);
    res_t r;
    r.pd  = IW'(p);
    r.sd  = IW'(s);
    r.mg  = MW'(m);
    r.amb = (a != 0);
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, k, act, exp_v, cyc);
    end
  endtask

  task automatic check_all_zero(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_predict"},   k, 64'(pd[k]),  64'd0);
      chk({nm, "_second"},    k, 64'(sd[k]),  64'd0);
      chk({nm, "_margin"},    k, 64'(mg[k]),  64'd0);
      chk({nm, "_ambiguous"}, k, 64'(amb[k]), 64'd0);
      chk({nm, "_busy"},      k, 64'(by[k]),  64'd0);
      chk({nm, "_done"},      k, 64'(dn[k]),  64'd0);
    end
  endtask

  task automatic set_all(input logic [SW-1:0] v);
    for (int i = 0; i < NC; i++) scores[i*SW +: SW] = v;
  endtask

  task automatic set_one(input int i, input logic [SW-1:0] v);
    scores[i*SW +: SW] = v;
  endtask

  task automatic vec_winner();
    set_all('0);
    set_one(1, 40'd900);
    set_one(2, 40'd10);
  endtask

  task automatic vec_tie();
    set_all('0);
    set_one(3, 40'd500);
    set_one(7, 40'd500);
  endtask

  task automatic vec_negative();
    set_all(40'hFF_FFFF_FF9C);
    set_one(5, 40'hFF_FFFF_FFFE);
    set_one(0, 40'hFF_FFFF_FFF7);
  endtask

  // Starts a scan from a negedge; lat is the expected start-edge-to-done distance.
  task automatic kick(input bit do_push, input int lat, input res_t a, input res_t b, input res_t c);
    exp_t e;
    int   e_cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    e_cyc = cyc;
    start = 1'b0;
    for (int k = 0; k < 3; k++) chk("busy_after_start", k, 64'(by[k]), 64'd1);
    if (do_push) begin
      e.r[0] = a;
      e.r[1] = b;
      e.r[2] = c;
      e.cyc  = 32'(e_cyc + lat);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("busy_after_done", k, 64'(by[k]), 64'd0);
      chk("done_one_cycle",  k, 64'(dn[k]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (dn[0] || dn[1] || dn[2]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 0, 64'(cyc), 64'(mon_e.cyc));
        for (int k = 0; k < 3; k++) begin
          chk("done",          k, 64'(dn[k]),  64'd1);
          chk("predict_digit", k, 64'(pd[k]),  64'(mon_e.r[k].pd));
          chk("second_digit",  k, 64'(sd[k]),  64'(mon_e.r[k].sd));
          chk("margin",        k, 64'(mg[k]),  64'(mon_e.r[k].mg));
          chk("ambiguous",     k, 64'(amb[k]), 64'(mon_e.r[k].amb));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    en     = 1'b1;
    start  = 1'b0;
    scores = '0;
    thr    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // single clear winner
    vec_winner();
    thr = 16'd100;
    kick(1'b1, 11, mk(1, 2, 890, 0), mk(1, 2, 890, 0), mk(1, 2, 890, 0));
    drain();

    // tie between classes 3 and 7
    vec_tie();
    thr = 16'd1;
    kick(1'b1, 11, mk(3, 7, 0, 1), mk(7, 3, 0, 1), mk(3, 7, 0, 1));
    drain();

    // negative scores: signed and unsigned orderings agree on the top two
    vec_negative();
    thr = 16'd8;
    kick(1'b1, 11, mk(5, 0, 7, 1), mk(5, 0, 7, 1), mk(5, 0, 7, 1));
    drain();

    // saturated margin, threshold equal to the saturated value
    set_all('0);
    set_one(0, 40'h00_4000_0000);
    thr = 16'hFFFF;
    kick(1'b1, 11, mk(0, 1, 65535, 0), mk(0, 9, 65535, 0), mk(0, 0, 65535, 0));
    drain();

    // stall 3 cycles, stray start and new scores mid-scan
    vec_winner();
    thr = 16'd100;
    kick(1'b1, 14, mk(1, 2, 890, 0), mk(1, 2, 890, 0), mk(1, 2, 890, 0));
    repeat (3) @(negedge clk);
    vec_negative();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    drain();

    // reset while idx = 4
    vec_tie();
    thr = 16'd1;
    kick(1'b0, 11, mk(0, 0, 0, 0), mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_scan");
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("idle_after_reset_busy", k, 64'(by[k]), 64'd0);

    // fresh scan after reset
    vec_negative();
    thr = 16'd8;
    kick(1'b1, 11, mk(5, 0, 7, 1), mk(5, 0, 7, 1), mk(5, 0, 7, 1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_argmax_scanner.md
# mlp_argmax_scanner

Parametrised sequential arg-max and top-2 stage for the output of the MLP inference path. It sits after the output-layer ReLU and replaces the single-cycle, fixed-10-class digit selector. It scans a packed score vector one class per cycle. It reports the winning class, the runner-up, a saturated confidence margin and an ambiguity flag, with a start/done handshake like the other MLP stages.

## Interface
- CLASS_NB, 10, number of classes scanned; must be ≥ 2
- SCORE_WIDTH, 40, width of one class score
- IDX_WIDTH, 4, class index width; must satisfy 2^IDX_WIDTH ≥ CLASS_NB
- SIGNED_SCORES, 1, 1 = two's-complement scores, 0 = unsigned
- TIE_HIGH, 0, 0 = on equal scores the lower index wins, 1 = the higher index wins
- MARGIN_WIDTH, 16, width of the margin output

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  clock enable; when low, all state and outputs hold
- start  in  1  request a scan; sampled only in IDLE
- scores_in  in  CLASS_NB*SCORE_WIDTH  class i at bits [SCORE_WIDTH*(i+1)-1 -: SCORE_WIDTH]
- threshold  in  MARGIN_WIDTH  ambiguity threshold, unsigned
- predict_digit  out  IDX_WIDTH  winning class index
- second_digit  out  IDX_WIDTH  runner-up class index
- margin  out  MARGIN_WIDTH  best minus second score, saturated
- ambiguous  out  1  margin < threshold
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE:**
  - On start=1 with en=1, register scores_in into an internal copy, set idx=0, go to SCAN.
  - Later changes on scores_in do not affect the scan in progress.
- **SCAN:** each en=1 cycle processes class idx. With s = score[idx]:
  - idx=0: best=s, best_idx=0; second=minimum representable value, second_idx=0.
  - s beats best: second ← best, best ← s, and the indices follow.
    - TIE_HIGH=0: "beats" means s > best.
    - TIE_HIGH=1: "beats" means s ≥ best.
  - Otherwise, s beats second under the same rule: second ← s, second_idx ← idx.
  - When idx = CLASS_NB−1, go to DONE.
- **DONE:**
  - Register predict_digit, second_digit, margin and ambiguous.
  - Assert done for exactly one en=1 cycle, then return to IDLE.
- **Comparisons:** signed when SIGNED_SCORES=1, unsigned otherwise.
- **Margin:**
  - Computed as best − second in SCORE_WIDTH+1 bits; the result is always ≥ 0.
  - Saturates to 2^MARGIN_WIDTH − 1 if larger.
  - ambiguous = (saturated margin < threshold), using the threshold value present in the DONE cycle.
- **Result outputs:** predict_digit, second_digit, margin and ambiguous hold their values until the next DONE.
- **start outside IDLE:** ignored; no queuing.
- **Reset, including mid-scan:**
  - Return to IDLE; the scan in progress is discarded.
  - All outputs go to 0, and done does not fire.

## Timing
- With en held high, start is sampled at rising edge E.
  - SCAN occupies edges E+1 through E+CLASS_NB.
  - done and the result outputs become valid after edge E+CLASS_NB+1.
  - Latency is CLASS_NB+1 cycles from the edge that samples start.
- busy goes high after edge E and low after the edge that leaves DONE.
- Each en=0 cycle adds exactly one cycle of latency; no class is skipped or repeated.
- Back-to-back operation: start may be asserted in the cycle after done. Minimum period is CLASS_NB+2 cycles.
- done and the result outputs update on the same edge; consumers sample results when done=1.

## Structure
- Shared MLP package holds:
  - the state encoding (IDLE/SCAN/DONE);
  - a `clog2` helper for IDX_WIDTH checks;
  - the default CLASS_NB=10 and SCORE_WIDTH=40 constants, matching the output dense layer.
- One sub-module: `mlp_score_compare`, a combinational signed/unsigned "beats" comparator parametrised on SCORE_WIDTH, SIGNED_SCORES and TIE_HIGH. It is instantiated twice: against best and against second.
- Elaboration-time checks: CLASS_NB ≥ 2 and 2^IDX_WIDTH ≥ CLASS_NB.

## Test plan
- **Single winner:** scores {0,900,10,0,…} (class 1 = 900, class 2 = 10), threshold=100 → predict_digit=1, second_digit=2, margin=890, ambiguous=0, done exactly 11 cycles after the start edge.
- **Tie rule:** classes 3 and 7 both 500, all others 0.
  - TIE_HIGH=0 → predict_digit=3, second_digit=7.
  - TIE_HIGH=1 → predict_digit=7, second_digit=3.
  - Both: margin=0; ambiguous=1 with threshold=1.
- **Signed vs unsigned:** all scores negative, class 5 = −2, class 0 = −9, rest −100.
  - SIGNED_SCORES=1 → predict_digit=5, second_digit=0, margin=7.
  - The same bit patterns with SIGNED_SCORES=0 → predict_digit=5 (0x…FE is the largest unsigned).
- **Saturation:** class 0 = 2^30, all others 0, MARGIN_WIDTH=16 → margin=65535.
- **Stall and ignore:**
  - Drop en for 3 cycles mid-scan → done arrives at exactly 14 cycles and results are unchanged.
  - Pulse start during SCAN → no extra done.
  - Change scores_in mid-scan → results reflect the captured vector.
- **Reset mid-scan:** assert reset at idx=4 → all outputs 0 and busy=0 immediately. After release, no done until a fresh start, and the next scan yields correct results.
